// File: rtl/md_scheduler.sv
// HI/LO multiply/divide sequencer: computes the result at issue, holds it in pending
// registers for the op latency, then commits to HI/LO and releases the D-stage stall.
module md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   pend_hi_q, pend_hi_d;
    logic [31:0]   pend_lo_q, pend_lo_d;
    logic          pend_ok_q, pend_ok_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic          is_md_op;
    logic [63:0]   prod_s, prod_u;
    logic [31:0]   abs_a, abs_b, safe_b, safe_abs_b;
    logic [31:0]   uq, ur, sq, sr, dq, dr;

    assign is_md_op = (md_op < 3'd4);

    // Signed product as the low 64 bits of the sign-extended operands.
    always_comb begin
        prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
        prod_u = {32'd0, src_a} * {32'd0, src_b};
    end

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as lo=0x80000000, hi=0.
    always_comb begin
        abs_a      = src_a[31] ? (~src_a + 32'd1) : src_a;
        abs_b      = src_b[31] ? (~src_b + 32'd1) : src_b;
        safe_b     = (src_b == 32'd0) ? 32'd1 : src_b;
        safe_abs_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
        uq         = abs_a / safe_abs_b;
        ur         = abs_a % safe_abs_b;
        sq         = (src_a[31] ^ src_b[31]) ? (~uq + 32'd1) : uq;
        sr         = src_a[31] ? (~ur + 32'd1) : ur;
        dq         = src_a / safe_b;
        dr         = src_a % safe_b;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_ok_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_ok_q <= pend_ok_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_ok_d = pend_ok_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        3'd0: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            pend_ok_d = 1'b1;
                            cnt_d     = CW'(MULT_CYCLES);
                            state_d   = BUSY;
                        end
                        3'd1: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            pend_ok_d = 1'b1;
                            cnt_d     = CW'(MULT_CYCLES);
                            state_d   = BUSY;
                        end
                        3'd2: begin
                            pend_hi_d = sr;
                            pend_lo_d = sq;
                            pend_ok_d = (src_b != 32'd0);
                            cnt_d     = CW'(DIV_CYCLES);
                            state_d   = BUSY;
                        end
                        3'd3: begin
                            pend_hi_d = dr;
                            pend_lo_d = dq;
                            pend_ok_d = (src_b != 32'd0);
                            cnt_d     = CW'(DIV_CYCLES);
                            state_d   = BUSY;
                        end
                        3'd4:    hi_d = src_a;
                        3'd5:    lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                // A start here cannot come from a well-formed pipeline and is dropped.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    if (pend_ok_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == BUSY);
        stall = md_use_d & ((state_q == BUSY) | (start & is_md_op));
        hi    = hi_q;
        lo    = lo_q;
    end
endmodule

// File: tb/tb_md_scheduler.sv
// Directed bench for md_scheduler: reset abort, mult/div results and latency,
// divide-by-zero, overflow, MTHI/MTLO, stall and start-while-busy.
module tb_md_scheduler;
  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        md_use_d;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests_run = 0;
  int tests_failed = 0;
  int n;

  md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .md_use_d (md_use_d),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op for a single cycle, then count busy cycles with stall checks.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic use_d, input int exp_cycles);
    int cyc;
    start = 1'b1; md_op = op; src_a = a; src_b = b; md_use_d = use_d;
    #1;
    check({tag, "_stall_issue"}, {31'd0, stall}, {31'd0, use_d});
    tick();
    start = 1'b0;
    #1;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      check({tag, "_stall_busy"}, {31'd0, stall}, {31'd0, use_d});
      cyc++;
      tick();
    end
    check({tag, "_busy_cycles"}, cyc, exp_cycles);
    check({tag, "_stall_drop"}, {31'd0, stall}, 32'd0);
    md_use_d = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; md_op = 3'd7; src_a = '0; src_b = '0; md_use_d = 1'b0;
    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b1;
    tick();

    // MULT aborted by reset during its second busy cycle
    start = 1'b1; md_op = 3'd0; src_a = 32'hFFFFFFFE; src_b = 32'd3;
    tick();
    start = 1'b0;
    check("abort_busy_started", {31'd0, busy}, 32'd1);
    tick();
    reset = 1'b0;
    #1;
    check("abort_busy_now", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (8) tick();
    check("abort_no_commit_hi", hi, 32'd0);
    check("abort_no_commit_lo", lo, 32'd0);
    check("abort_idle", {31'd0, busy}, 32'd0);

    // MULT -2 * 3, D-stage stalled throughout
    start = 1'b1; md_op = 3'd0; src_a = 32'hFFFFFFFE; src_b = 32'd3; md_use_d = 1'b1;
    tick();
    start = 1'b0;
    check("mult_no_bypass_lo", lo, 32'd0);
    reset = 1'b1;
    n = 1;
    tick();
    while (busy === 1'b1 && n < 40) begin
      check("mult_stall_busy", {31'd0, stall}, 32'd1);
      n++;
      tick();
    end
    check("mult_busy_cycles", n, 5);
    check("mult_stall_drop", {31'd0, stall}, 32'd0);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFA);
    md_use_d = 1'b0;

    run_op("multu", 3'd1, 32'hFFFFFFFE, 32'd3, 1'b1, 5);
    check("multu_hi", hi, 32'h00000002);
    check("multu_lo", lo, 32'hFFFFFFFA);

    run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2, 1'b1, 10);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);

    run_op("divu_zero", 3'd3, 32'd7, 32'd0, 1'b0, 10);
    check("divu_zero_lo", lo, 32'hFFFFFFFD);
    check("divu_zero_hi", hi, 32'hFFFFFFFF);

    run_op("div_pos_neg", 3'd2, 32'd7, 32'hFFFFFFFE, 1'b0, 10);
    check("div_pos_neg_lo", lo, 32'hFFFFFFFD);
    check("div_pos_neg_hi", hi, 32'h00000001);

    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10);
    check("div_ovf_lo", lo, 32'h80000000);
    check("div_ovf_hi", hi, 32'h00000000);

    run_op("divu", 3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 10);
    check("divu_lo", lo, 32'h7FFFFFFC);
    check("divu_hi", hi, 32'h00000001);

    // MTHI then MTLO back-to-back
    start = 1'b1; md_op = 3'd4; src_a = 32'h12345678; src_b = 32'd0; md_use_d = 1'b1;
    #1;
    check("mthi_stall", {31'd0, stall}, 32'd0);
    tick();
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    md_op = 3'd5; src_a = 32'h9ABCDEF0;
    #1;
    check("mtlo_stall", {31'd0, stall}, 32'd0);
    tick();
    start = 1'b0; md_use_d = 1'b0;
    check("mtlo_lo", lo, 32'h9ABCDEF0);
    check("mtlo_hi_kept", hi, 32'h12345678);
    check("mtlo_busy", {31'd0, busy}, 32'd0);

    // md_op 6 is a no-op
    start = 1'b1; md_op = 3'd6; src_a = 32'hDEADBEEF;
    tick();
    start = 1'b0;
    check("nop_busy", {31'd0, busy}, 32'd0);
    check("nop_hi", hi, 32'h12345678);
    check("nop_lo", lo, 32'h9ABCDEF0);

    // DIV issued while a MULT is in flight is dropped
    start = 1'b1; md_op = 3'd0; src_a = 32'd6; src_b = 32'd7;
    tick();
    md_op = 3'd2; src_a = 32'd100; src_b = 32'd3;
    n = 1;
    tick();
    start = 1'b0;
    n++;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check("ignore_busy_cycles", n, 6);
    check("ignore_hi", hi, 32'd0);
    check("ignore_lo", lo, 32'h0000002A);
    repeat (3) tick();
    check("ignore_stays_idle", {31'd0, busy}, 32'd0);
    check("ignore_lo_kept", lo, 32'h0000002A);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
